// File: rtl/serial_regfile.sv
// Bit-serial register file: rotates a source register out LSB first while
// shifting serial data (optionally sign-extended) into a destination register.
module serial_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(WIDTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [AW-1:0]          i_rs_addr,
    input  logic [AW-1:0]          i_rd_addr,
    input  logic                   i_we,
    input  logic                   i_sign_ext,
    input  logic [LW-1:0]          i_len,
    input  logic                   i_stall,
    input  logic                   i_data_in,
    output logic                   o_data_out,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [DEPTH*WIDTH-1:0] o_regs
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [LW-1:0]     cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic [AW-1:0]     rs_q, rs_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic              we_q, we_d;
    logic              sgn_q, sgn_d;
    logic [LW-1:0]     len_q, len_d;

    logic              active;
    logic              real_bit;
    logic              in_bit;
    logic [AW-1:0]     out_addr;

    assign active   = (state_q == SHIFT) && !i_stall;
    assign real_bit = cnt_q < len_q;
    assign in_bit   = (!sgn_q || real_bit) ? i_data_in : sign_q;
    assign out_addr = (state_q == IDLE) ? i_rs_addr : rs_q;

    assign o_data_out = regs_q[out_addr][0];
    assign o_busy     = (state_q == SHIFT);
    assign o_done     = (state_q == DONE);

    always_comb begin
        o_regs = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_regs[k*WIDTH +: WIDTH] = regs_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        rs_d    = rs_q;
        rd_d    = rd_q;
        we_d    = we_q;
        sgn_d   = sgn_q;
        len_d   = len_q;
        for (int k = 0; k < DEPTH; k++) begin
            regs_d[k] = regs_q[k];
        end

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (i_start) begin
                    rs_d    = i_rs_addr;
                    rd_d    = i_rd_addr;
                    we_d    = i_we;
                    sgn_d   = i_sign_ext;
                    len_d   = i_len;
                    cnt_d   = '0;
                    sign_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (active) begin
                    // Destination write wins over the rotate when rs == rd
                    for (int k = 0; k < DEPTH; k++) begin
                        if (we_q && AW'(k) == rd_q) begin
                            regs_d[k] = {in_bit, regs_q[k][WIDTH-1:1]};
                        end else if (AW'(k) == rs_q) begin
                            regs_d[k] = {regs_q[k][0], regs_q[k][WIDTH-1:1]};
                        end
                    end
                    if (real_bit) begin
                        sign_d = i_data_in;
                    end
                    if (cnt_q == LW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            rs_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            len_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            rs_q    <= rs_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            sgn_q   <= sgn_d;
            len_q   <= len_d;
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

endmodule

// File: tb/tb_serial_regfile.sv
// Directed bench for serial_regfile (WIDTH=8, DEPTH=4).
module tb_serial_regfile;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  rs_addr;
    logic [1:0]  rd_addr;
    logic        we;
    logic        sign_ext;
    logic [3:0]  len;
    logic        stall;
    logic        data_in;
    logic        data_out;
    logic        busy;
    logic        done;
    logic [31:0] regs;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt;

    serial_regfile #(.WIDTH(8), .DEPTH(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_rs_addr  (rs_addr),
        .i_rd_addr  (rd_addr),
        .i_we       (we),
        .i_sign_ext (sign_ext),
        .i_len      (len),
        .i_stall    (stall),
        .i_data_in  (data_in),
        .o_data_out (data_out),
        .o_busy     (busy),
        .o_done     (done),
        .o_regs     (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept a transfer; returns at the first negedge in SHIFT.
    task automatic do_start(input logic [1:0] s, input logic [1:0] d,
                            input logic w, input logic sg,
                            input logic [3:0] l);
        @(negedge clk);
        rs_addr  = s;
        rd_addr  = d;
        we       = w;
        sign_ext = sg;
        len      = l;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rs_addr  = 2'd0;
        rd_addr  = 2'd0;
        we       = 1'b0;
        sign_ext = 1'b0;
        len      = 4'd0;
    endtask

    task automatic feed(input logic [7:0] v);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            data_in = v[i];
            busy_cnt += int'(busy);
            @(negedge clk);
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_gone"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rs_addr  = 2'd0;
        rd_addr  = 2'd0;
        we       = 1'b0;
        sign_ext = 1'b0;
        len      = 4'd0;
        stall    = 1'b0;
        data_in  = 1'b0;

        #12;
        chk("rst_regs", regs, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // serial write 0xA5 into r1
        do_start(2'd0, 2'd1, 1'b1, 1'b0, 4'd0);
        feed(8'hA5);
        chk("wr_busy_cycles", 32'(busy_cnt), 32'd8);
        check_done("wr");
        chk("wr_regs", regs, 32'h0000_A500);

        // idle read port follows i_rs_addr
        rs_addr = 2'd1;
        #1;
        chk("idle_dout_r1", 32'(data_out), 32'd1);
        rs_addr = 2'd0;
        #1;
        chk("idle_dout_r0", 32'(data_out), 32'd0);

        // copy r1 -> r2 with o_data_out looped back
        do_start(2'd1, 2'd2, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            data_in = data_out;
            @(negedge clk);
        end
        check_done("cp");
        chk("cp_regs", regs, 32'h00A5_A500);

        // sign extend bits 1,0,1,1 into r3; trailing bits ignored
        do_start(2'd0, 2'd3, 1'b1, 1'b1, 4'd4);
        feed(8'b0000_1101);
        check_done("sx4");
        chk("sx4_regs", regs, 32'hFDA5_A500);

        // len=0 in sign mode zero-fills
        do_start(2'd0, 2'd3, 1'b1, 1'b1, 4'd0);
        feed(8'hFF);
        check_done("sx0");
        chk("sx0_regs", regs, 32'h00A5_A500);

        // len=8 never extends
        do_start(2'd0, 2'd3, 1'b1, 1'b1, 4'd8);
        feed(8'h35);
        check_done("sx8");
        chk("sx8_regs", regs, 32'h35A5_A500);

        // asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_regs", regs, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // stall 3 cycles after bit 2; start pulse during SHIFT ignored
        do_start(2'd0, 2'd1, 1'b1, 1'b0, 4'd0);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                stall = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    data_in = 1'b0;
                    if (j == 1) begin
                        start   = 1'b1;
                        rd_addr = 2'd2;
                        we      = 1'b1;
                    end else begin
                        start   = 1'b0;
                        rd_addr = 2'd0;
                        we      = 1'b0;
                    end
                    busy_cnt += int'(busy);
                    @(negedge clk);
                end
                stall = 1'b0;
            end
            data_in = (i == 5) ? 1'b1 : ((8'hA5 >> i) & 8'h01) != 0;
            if (i == 5) begin
                start   = 1'b1;
                rd_addr = 2'd3;
                we      = 1'b1;
            end else begin
                start   = 1'b0;
                rd_addr = 2'd0;
                we      = 1'b0;
            end
            busy_cnt += int'(busy);
            @(negedge clk);
        end
        start = 1'b0;
        rd_addr = 2'd0;
        we = 1'b0;
        chk("st_busy_cycles", 32'(busy_cnt), 32'd11);
        check_done("st");
        chk("st_regs", regs, 32'h0000_A500);

        // reset after bit 4 of a write, then a fresh transfer
        do_start(2'd0, 2'd0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            data_in = 1'b1;
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_regs", regs, 32'h0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_idle", 32'(busy), 32'd0);
        do_start(2'd0, 2'd2, 1'b1, 1'b0, 4'd0);
        feed(8'h5A);
        chk("fresh_busy_cycles", 32'(busy_cnt), 32'd8);
        check_done("fresh");
        chk("fresh_regs", regs, 32'h005A_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_regfile.md
SERIAL_REGFILE -- requirements
Module: serial_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per register (>= 2).
REQ-002 SHALL have parameter DEPTH, default 4, number of registers (>= 2).
REQ-003 SHALL have local parameters AW = $clog2(DEPTH) and LW = $clog2(WIDTH+1).
REQ-004 SHALL have port i_clk, input, 1, single clock; all state on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port i_start, input, 1, request a WIDTH-bit serial transfer.
REQ-007 SHALL have port i_rs_addr, input, AW, source register, sampled at accepted start.
REQ-008 SHALL have port i_rd_addr, input, AW, destination register, sampled at accepted start.
REQ-009 SHALL have port i_we, input, 1, destination write enable, sampled at accepted start.
REQ-010 SHALL have port i_sign_ext, input, 1, sign-extension mode, sampled at accepted start.
REQ-011 SHALL have port i_len, input, LW, count of real input bits in sign mode, sampled at accepted start.
REQ-012 SHALL have port i_stall, input, 1, freeze the transfer this cycle.
REQ-013 SHALL have port i_data_in, input, 1, serial write bit, LSB first.
REQ-014 SHALL have port o_data_out, output, 1, bit 0 of the latched source register (combinational).
REQ-015 SHALL have port o_busy, output, 1, high while in SHIFT.
REQ-016 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port o_regs, output, DEPTH*WIDTH, all registers flattened; register k at bits [k*WIDTH +: WIDTH].

Function
REQ-018 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-019 SHALL accept i_start only in IDLE or DONE: latch rs, rd, we, sign, len; clear bit counter and sign latch; enter SHIFT next cycle.
REQ-020 SHALL ignore i_start while in SHIFT, with no effect on latched fields.
REQ-021 SHALL define an active cycle as SHIFT with i_stall=0; only active cycles advance the counter (0..WIDTH-1) or modify registers.
REQ-022 SHALL rotate the source right on each active cycle ({rs[0], rs[WIDTH-1:1]}), so that a read-only transfer leaves it unchanged after WIDTH cycles.
REQ-023 SHALL shift the destination right on each active cycle with latched we=1, inserting the computed input bit at the MSB.
REQ-024 SHALL compute the input bit as i_data_in when sign=0 or counter < len; otherwise it SHALL be the sign latch.
REQ-025 SHALL load the sign latch with i_data_in on every active cycle where counter < len.
REQ-026 SHALL produce all-zero destination fill for len=0 in sign mode.
REQ-027 SHALL never apply extension when len >= WIDTH.
REQ-028 SHALL apply the destination shift and suppress the rotate when rs == rd with we=1.
REQ-029 SHALL leave all non-addressed registers unchanged.
REQ-030 SHALL leave SHIFT for DONE after the active cycle with counter = WIDTH-1.
REQ-031 SHALL assert o_done in DONE for exactly one cycle, with o_busy low in DONE.
REQ-032 SHALL hold all state under i_stall, while o_data_out still reflects the current source bit 0.
REQ-033 SHALL produce o_data_out = bit 0 of register i_rs_addr when in IDLE.

Reset
REQ-034 SHALL, on i_rst_n low at any time including mid-transfer, immediately clear all registers to 0, FSM to IDLE, counter and sign latch to 0, and latched fields to 0.
REQ-035 SHALL drive o_busy=0, o_done=0, o_regs=0 and o_data_out=0 during and after reset until a transfer modifies state.

Verification (WIDTH=8, DEPTH=4)
REQ-036 SHALL cover reset: assert i_rst_n=0 asynchronously mid-cycle -> o_regs=0, o_busy=0, o_done=0 immediately.
REQ-037 SHALL cover serial write: start rd=1, we=1, sign=0, feed 0xA5 LSB first -> o_busy high 8 cycles, o_done one pulse, r1=0xA5, others 0.
REQ-038 SHALL cover copy: bench loops o_data_out to i_data_in, start rs=1, rd=2, we=1 -> r2=0xA5, r1=0xA5 unchanged.
REQ-039 SHALL cover sign extension: rd=3, sign=1, len=4, bits 1,0,1,1 -> r3=0xFD; repeat with len=0 -> r3=0x00.
REQ-040 SHALL cover stall: i_stall high 3 cycles after bit 2 of the 0xA5 write -> o_busy high 11 cycles, r1=0xA5; i_start pulsed during SHIFT is ignored.
REQ-041 SHALL cover reset mid-operation: i_rst_n low after bit 4 -> all registers 0 and IDLE; a fresh start then completes normally.
